// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file access arbiter.
package regfile_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Index of the last register; the debug walk stops here and never wraps.
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DUMP_RD   = 3'd1,
    ST_DUMP_SEND = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_dbg_fsm.sv
// Debug sequencer: walks the register index for dump and clear operations and
// owns the dump stream.
//
// Dump stream handshake: o-side dbg_valid rises with dbg_data loaded; both stay
// stable until a posedge sees dbg_valid & dbg_ready, which consumes the word.
// The sink may hold dbg_ready high or low freely; valid never depends on ready.
import regfile_pkg::*;

module regfile_dbg_fsm (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          dump_start,
  input  logic          clear_start,
  input  logic [DW-1:0] rf_data_rs,
  input  logic          dbg_ready,
  output state_t        state,
  output logic [AW-1:0] idx,
  output logic [DW-1:0] dbg_data,
  output logic          dbg_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Busy only while the sequencer is actually driving the register file.
  assign busy = (state == ST_DUMP_RD) || (state == ST_DUMP_SEND) || (state == ST_CLEAR);

  // Sequencer state, index, dump word and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dump_start || clear_start) begin
            if (!halted) begin
              err <= 1'b1;
            end else if (dump_start) begin
              state <= ST_DUMP_RD;
              idx   <= '0;
            end else begin
              state <= ST_CLEAR;
              idx   <= '0;
            end
          end
        end
        ST_DUMP_RD: begin
          if (!halted) begin
            state     <= ST_IDLE;
            dbg_valid <= 1'b0;
            err       <= 1'b1;
          end else begin
            dbg_data  <= rf_data_rs;
            dbg_valid <= 1'b1;
            state     <= ST_DUMP_SEND;
          end
        end
        ST_DUMP_SEND: begin
          if (!halted) begin
            state     <= ST_IDLE;
            dbg_valid <= 1'b0;
            err       <= 1'b1;
          end else if (dbg_ready) begin
            dbg_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_DUMP_RD;
            end
          end
        end
        ST_CLEAR: begin
          if (!halted) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (idx == LAST_IDX) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the register file ports between the pipeline and the debug unit.
// The pipeline owns the ports except while a debug operation is running.
import regfile_pkg::*;

module regfile_access_arbiter (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_pipe_halted,
  input  logic          i_wb_wenable,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [AW-1:0] i_id_addr_rs,
  input  logic [AW-1:0] i_id_addr_rt,
  output logic [DW-1:0] o_id_data_rs,
  output logic [DW-1:0] o_id_data_rt,
  output logic          o_rf_wenable,
  output logic [AW-1:0] o_rf_addr_rs,
  output logic [AW-1:0] o_rf_addr_rt,
  output logic [AW-1:0] o_rf_addr_data,
  output logic [DW-1:0] o_rf_data,
  input  logic [DW-1:0] i_rf_data_rs,
  input  logic [DW-1:0] i_rf_data_rt,
  input  logic          i_dbg_dump_start,
  input  logic          i_dbg_clear_start,
  output logic [DW-1:0] o_dbg_data,
  output logic          o_dbg_valid,
  input  logic          i_dbg_ready,
  output logic          o_dbg_busy,
  output logic          o_dbg_done,
  output logic          o_dbg_err
);

  state_t        state;
  logic [AW-1:0] idx;

  regfile_dbg_fsm u_fsm (
    .clk         (clk),
    .rst_n       (i_rst_n),
    .halted      (i_pipe_halted),
    .dump_start  (i_dbg_dump_start),
    .clear_start (i_dbg_clear_start),
    .rf_data_rs  (i_rf_data_rs),
    .dbg_ready   (i_dbg_ready),
    .state       (state),
    .idx         (idx),
    .dbg_data    (o_dbg_data),
    .dbg_valid   (o_dbg_valid),
    .busy        (o_dbg_busy),
    .done        (o_dbg_done),
    .err         (o_dbg_err)
  );

  // Decode always sees the register file outputs, whoever drives the addresses.
  assign o_id_data_rs = i_rf_data_rs;
  assign o_id_data_rt = i_rf_data_rt;

  // Port mux: pipeline pass-through unless a debug state owns the register file.
  // During a dump the write address is ~idx so it never matches the read
  // address and the regfile write-through bypass cannot alter the read data.
  always_comb begin
    o_rf_wenable   = i_wb_wenable;
    o_rf_addr_rs   = i_id_addr_rs;
    o_rf_addr_rt   = i_id_addr_rt;
    o_rf_addr_data = i_wb_addr;
    o_rf_data      = i_wb_data;
    case (state)
      ST_DUMP_RD, ST_DUMP_SEND: begin
        o_rf_wenable   = 1'b0;
        o_rf_addr_rs   = idx;
        o_rf_addr_rt   = idx;
        o_rf_addr_data = ~idx;
        o_rf_data      = '0;
      end
      ST_CLEAR: begin
        o_rf_wenable   = 1'b1;
        o_rf_addr_rs   = ~idx;
        o_rf_addr_rt   = ~idx;
        o_rf_addr_data = idx;
        o_rf_data      = '0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the single write port and two read ports of the 32x32 register file between the pipeline (decode reads, writeback writes) and the debug unit.
- The debug unit has two operations: dump all registers over a valid/ready stream, and clear all registers to zero.
- Both operations are sequenced by an internal FSM and run only while the pipeline is halted.
- The block sits between the decode/writeback stages, the debug UART unit and the register file.

Parameters:
NREG, 32, number of architectural registers
AW, 5, register address width (clog2 NREG)
DW, 32, data width

Ports:
clk  in  1  system clock (posedge)
i_rst_n  in  1  asynchronous active-low reset
i_pipe_halted  in  1  pipeline frozen; debug ops permitted
i_wb_wenable  in  1  pipeline writeback enable
i_wb_addr  in  AW  pipeline writeback address
i_wb_data  in  DW  pipeline writeback data
i_id_addr_rs  in  AW  decode rs address
i_id_addr_rt  in  AW  decode rt address
o_id_data_rs  out  DW  rs data to decode (combinational from i_rf_data_rs)
o_id_data_rt  out  DW  rt data to decode (combinational from i_rf_data_rt)
o_rf_wenable  out  1  to regfile write enable
o_rf_addr_rs  out  AW  to regfile rs address
o_rf_addr_rt  out  AW  to regfile rt address
o_rf_addr_data  out  AW  to regfile write address
o_rf_data  out  DW  to regfile write data
i_rf_data_rs  in  DW  regfile rs output (updates on negedge)
i_rf_data_rt  in  DW  regfile rt output
i_dbg_dump_start  in  1  single-cycle request to dump all registers
i_dbg_clear_start  in  1  single-cycle request to zero all registers
o_dbg_data  out  DW  dumped register value
o_dbg_valid  out  1  o_dbg_data valid
i_dbg_ready  in  1  debug sink accepts o_dbg_data
o_dbg_busy  out  1  debug op owns regfile
o_dbg_done  out  1  one-cycle pulse when op completes
o_dbg_err  out  1  one-cycle pulse on rejected or aborted op

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, idx=0; o_dbg_data=0.
  - o_dbg_valid, o_dbg_busy, o_dbg_done and o_dbg_err all 0.
  - Takes effect immediately, including mid-operation; partial clears are not undone.
- IDLE (pipeline owns the regfile):
  - o_rf_* = pipeline signals, pass-through and combinational.
  - o_dbg_busy=0.
- Start handling, sampled in IDLE:
  - i_dbg_dump_start=1 with halted=1 -> DUMP_RD, idx=0.
  - Otherwise i_dbg_clear_start=1 with halted=1 -> CLEAR, idx=0.
  - Both starts asserted together -> dump wins and clear is ignored (no err).
  - Any start with halted=0 -> stay in IDLE, o_dbg_err pulses next cycle.
  - Starts received while busy are ignored.
- Debug states drive the regfile as follows:
  - o_dbg_busy=1.
  - Pipeline writeback is not forwarded (dropped).
  - o_id_data_* still mirror the regfile outputs.
- DUMP_RD:
  - rs=rt=idx, o_rf_addr_data=~idx (bitwise invert, never equal to idx, so the regfile bypass cannot trigger), wenable=0.
  - Lasts 1 cycle.
  - At its closing posedge: o_dbg_data <= i_rf_data_rs, o_dbg_valid <= 1 -> DUMP_SEND.
- DUMP_SEND:
  - Same address drive as DUMP_RD; o_dbg_data and o_dbg_valid held stable.
  - Handshake = valid & ready on a posedge. On handshake, o_dbg_valid <= 0, then:
    - idx==NREG-1 -> DONE;
    - else idx <= idx+1 -> DUMP_RD.
  - Throughput: 1 word per 2 cycles at best.
- CLEAR:
  - wenable=1, o_rf_addr_data=idx, o_rf_data=0, rs=rt=~idx; one register per cycle.
  - idx==NREG-1 -> DONE; else idx++.
  - Total 32 cycles.
- DONE:
  - o_dbg_done=1 for exactly one cycle, busy=0, -> IDLE.
- Abort: i_pipe_halted falling in any debug state:
  - Next state IDLE, o_dbg_valid <= 0, o_dbg_err pulses, no done.
- Counter idx is AW bits; terminal compare is against NREG-1, with no wrap beyond it.

Decomposition:
- Shared package (regfile_pkg):
  - AW, DW, NREG constants;
  - state encoding IDLE/DUMP_RD/DUMP_SEND/CLEAR/DONE (3 bits).
- Single natural sub-module: regfile_dbg_fsm (state, idx, dbg handshake).
- The top level holds the port muxes and instantiates the fsm.

Test Plan:
- Preload regs r[i]=i*4 via pipeline wb, halt, pulse dump_start, ready=1 -> 32 beats with data 0,4,...,124, done pulses 1 cycle after beat 31, total 64 cycles.
- Dump with ready toggling 1-in-3 -> no beat lost or duplicated; o_dbg_data stable while valid&!ready.
- Halt, clear_start -> 32 consecutive writes of 0 to addr 0..31, done at cycle 33; subsequent dump returns all zeros; wb_wenable pulses during clear are not forwarded.
- dump_start with halted=0 -> no busy, err pulses once; dump_start and clear_start in the same cycle -> dump runs, no writes occur.
- Deassert halted at beat 10 of dump -> IDLE next cycle, err pulse, no done, pipeline regains ports; async reset at clear idx=7 -> all outputs 0 immediately, regs 0..6 zeroed, regs 7..31 unchanged.
